// File: rtl/uart_tx_port.sv
// rtl/uart_tx_port.sv - memory-mapped UART transmitter with byte FIFO, 8N1 (8E1 with UART_TX_PARITY_EN)
// Optional macro: UART_TX_PARITY_EN inserts an even-parity bit between data and stop.
`timescale 1ns/1ps
module uart_tx_port #(
   parameter int unsigned BAUD_DIV   = 10417,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter logic [31:0] TX_ADDR    = 32'h40000018,
   parameter logic [31:0] STAT_ADDR  = 32'h40000020
) (
   input  logic        sysclk,
   input  logic        reset,
   input  logic [31:0] Address,
   input  logic [31:0] Write_Data,
   input  logic        MemWrite,
   input  logic        MemRead,
   output logic [31:0] Read_Data,
   output logic        tx
);

   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [15:0]   BAUD_LAST = 16'(BAUD_DIV - 1);
   localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef UART_TX_PARITY_EN
      S_PARITY,
`endif
      S_STOP
   } state_t;

   state_t        state, next_state;
   logic [15:0]   baud_cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shift, shift_next;
   logic          tx_next;
   logic [7:0]    fifo_mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic          ovf;
   logic          pop, push_req, do_push, full, busy, stat_rd, baud_done;
`ifdef UART_TX_PARITY_EN
   logic          parity;
`endif

   logic unused_bits;
   assign unused_bits = ^Write_Data[31:8];

   assign stat_rd   = MemRead && (Address == STAT_ADDR);
   assign push_req  = MemWrite && (Address == TX_ADDR);
   assign full      = (count == DEPTH_C);
   assign do_push   = push_req && !full;
   assign busy      = (state != S_IDLE) || (count != '0);
   assign baud_done = (baud_cnt == BAUD_LAST);

   always_comb begin
      Read_Data = 32'h0;
      if (stat_rd)
         Read_Data = {24'h0, 5'(count), ovf, full, busy};
   end

   always_comb begin
      next_state = state;
      pop        = 1'b0;
      shift_next = shift;
      tx_next    = 1'b1;
      case (state)
         S_IDLE: begin
            if (count != '0) begin
               pop        = 1'b1;
               next_state = S_START;
            end
         end
         S_START: begin
            if (baud_done)
               next_state = S_DATA;
         end
         S_DATA: begin
            if (baud_done) begin
               if (bit_idx == 3'd7)
`ifdef UART_TX_PARITY_EN
                  next_state = S_PARITY;
`else
                  next_state = S_STOP;
`endif
               else
                  shift_next = {1'b0, shift[7:1]};
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            if (baud_done)
               next_state = S_STOP;
         end
`endif
         S_STOP: begin
            // Chain straight into the next start bit so queued bytes stream without gaps.
            if (baud_done) begin
               if (count != '0) begin
                  pop        = 1'b1;
                  next_state = S_START;
               end else begin
                  next_state = S_IDLE;
               end
            end
         end
         default: next_state = S_IDLE;
      endcase
      if (pop)
         shift_next = fifo_mem[rd_ptr];
      case (next_state)
         S_START:  tx_next = 1'b0;
         S_DATA:   tx_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
         S_PARITY: tx_next = parity;
`endif
         default:  tx_next = 1'b1;
      endcase
   end

   always_ff @(posedge sysclk) begin
      if (do_push)
         fifo_mem[wr_ptr] <= Write_Data[7:0];
   end

   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) begin
         state    <= S_IDLE;
         tx       <= 1'b1;
         baud_cnt <= 16'h0;
         bit_idx  <= 3'd0;
         shift    <= 8'h0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         ovf      <= 1'b0;
      end else begin
         state <= next_state;
         tx    <= tx_next;
         shift <= shift_next;
         if (next_state != state || baud_done || state == S_IDLE)
            baud_cnt <= 16'h0;
         else
            baud_cnt <= baud_cnt + 16'd1;
         if (state != S_DATA)
            bit_idx <= 3'd0;
         else if (baud_done)
            bit_idx <= bit_idx + 3'd1;
         if (do_push)
            wr_ptr <= wr_ptr + PW'(1);
         if (pop)
            rd_ptr <= rd_ptr + PW'(1);
         case ({do_push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         // A dropped push outranks a same-cycle status read clearing the flag.
         if (push_req && full)
            ovf <= 1'b1;
         else if (stat_rd)
            ovf <= 1'b0;
      end
   end

`ifdef UART_TX_PARITY_EN
   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset)
         parity <= 1'b0;
      else if (pop)
         parity <= ^fifo_mem[rd_ptr];
   end
`endif

endmodule
